i2c_slave_controller: RTL and testbench
=======================================

# i2c_slave_controller

Synchronous I2C target (slave) controller that answers the team's I2C master controller on the same two-wire bus. It oversamples SCL/SDA with the system clock, detects START/STOP, matches a 7-bit address, acknowledges, and then receives write bytes or returns read bytes over a byte-wide user interface. It sits at the far end of `i2c_sda_inout`/`i2c_scl_inout` as a bus-functional peer and serves as a synthesizable target for system-level tests.

## Interface
- `SLAVE_ADDR`, 7'b1010101, 7-bit address this target responds to.
- `i2c_clock_in`  input  1  system clock; all logic is on its rising edge.
- `i2c_reset_in`  input  1  reset; asynchronous, active-high.
- `i2c_scl_inout`  inout  1  serial clock line; sampled only and never driven (held `z`).
- `i2c_sda_inout`  inout  1  serial data line; driven only low (open-drain), otherwise `z`.
- `slave_data_tx`  input  8  byte returned on a read; sampled in the cycle `tx_req` is high.
- `tx_req`  output  1  one-cycle pulse requesting the next read byte.
- `slave_data_rx`  output  8  last byte written by the master; held until the next byte arrives.
- `rx_valid`  output  1  one-cycle pulse when `slave_data_rx` updates.
- `busy`  output  1  high from an address match until STOP or NACK-return to IDLE.
- `rw_out`  output  1  R/W bit of the current transfer (1 = read).

## Operation
- SCL and SDA each pass through a 2-flop synchronizer. Edges are detected on the synchronized values.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- States and transitions:
  - IDLE -> ADDR on START.
  - ADDR: shift 8 bits MSB-first on SCL rising. The 8th bit is R/W.
    - On address match, -> ADDR_ACK.
    - On mismatch, -> IDLE; SDA stays released for the rest of the transfer.
  - ADDR_ACK: drive SDA low for one SCL clock.
    - Then -> WR_DATA if R/W=0.
    - Or -> RD_DATA if R/W=1; `tx_req` pulses when entering ADDR_ACK.
  - WR_DATA: shift 8 bits, then -> WR_ACK. Load `slave_data_rx` and pulse `rx_valid` on the 8th SCL rising edge.
  - WR_ACK: drive SDA low for one SCL clock, then -> WR_DATA.
  - RD_DATA: drive the tx shift register MSB-first. Each bit is placed after SCL falling. After 8 bits, release SDA and -> RD_ACK.
  - RD_ACK: sample SDA on SCL rising.
    - Low (ACK): pulse `tx_req`, load the next byte, -> RD_DATA.
    - High (NACK): -> IDLE, keep SDA released.
- STOP in any state -> IDLE, release SDA, `busy`=0.
- Repeated START in any state -> ADDR. Counters and shift registers are cleared; `slave_data_rx` keeps its value.
- Bit counter is 3 bits and wraps 7 -> 0 at each byte boundary.

## Timing
- Reset values:
  - SDA released (`z`).
  - `slave_data_rx`=8'h00; `tx_req`, `rx_valid`, `busy`, `rw_out`=0.
  - State = IDLE.
- Reset mid-transfer releases SDA within the same cycle (asynchronous).
- Detection latency: 3 `i2c_clock_in` cycles from a pin change to the state update (2 sync + 1 edge register).
- SDA drive changes exactly 1 cycle after a detected SCL falling edge, never while synchronized SCL is high.
- ACK low is released 1 cycle after the SCL falling edge that ends the ACK clock.
- `rx_valid` occurs 1 cycle after the detected 8th SCL rising edge of a write byte.
- `tx_req` occurs 1 cycle after the detected SCL rising edge of the ACK/address bit. `slave_data_tx` is sampled in that same cycle.
- Bus requirement: SCL high and low phases must each be ≥4 `i2c_clock_in` cycles. SDA must be stable ≥4 cycles around SCL rising.
- Simultaneous START and STOP detection cannot occur (same SDA edge). If SCL and SDA edges land in the same cycle, the SCL edge is processed and the SDA edge is not treated as START/STOP.

## Configuration
- `I2C_SLAVE_GEN_CALL_EN` defined:
  - Address 7'b0000000 with R/W=0 (general call) is also ACKed and enters WR_DATA.
  - General call with R/W=1 is not ACKed.
- `I2C_SLAVE_GEN_CALL_EN` undefined: only `SLAVE_ADDR` is ACKed; general call behaves as an address mismatch.

## Test plan
- Write: START, addr 7'b1010101 + W, data 8'b11010011, STOP -> SDA low on both ACK clocks; `rx_valid` pulses once; `slave_data_rx`=8'hD3; `busy` high during the transfer, 0 after STOP.
- Read: START, addr 1010101 + R, `slave_data_tx`=8'b10011001, master NACK -> SDA carries 1,0,0,1,1,0,0,1 on successive SCL highs; one `tx_req`; back to IDLE with SDA `z`.
- Mismatch: addr 7'b1011001 + W -> SDA never driven low; `rx_valid`/`tx_req` never pulse; `busy` stays 0.
- Multi-byte read with ACK then repeated START into a write of 8'h3C: two `tx_req` pulses, then `rw_out`=0, `slave_data_rx`=8'h3C.
- Reset asserted mid read byte while SDA is driven low -> SDA `z` immediately; all outputs at reset values; next START is handled normally.
- General call 7'b0000000 + W, data 8'hA5: with the macro, ACK and `slave_data_rx`=8'hA5; without it, no ACK and no `rx_valid`.

Source files
------------

// File: rtl/i2c_slave_controller.sv
// I2C target: 2-flop pin sync, START/STOP detect, 7-bit address match, byte-wide rx/tx; I2C_SLAVE_GEN_CALL_EN also ACKs general-call writes.
// Latency: 3 clocks pin-to-state, SDA drive 1 clock after detected SCL fall; no backpressure, tx byte sampled while tx_req is high.
`timescale 1ns/1ps
module i2c_slave_controller #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1010101
) (
    input  logic       i2c_clock_in,
    input  logic       i2c_reset_in,
    inout  wire        i2c_scl_inout,
    inout  wire        i2c_sda_inout,
    input  logic [7:0] slave_data_tx,
    output logic       tx_req,
    output logic [7:0] slave_data_rx,
    output logic       rx_valid,
    output logic       busy,
    output logic       rw_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK
    } state_t;

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_prev_q, sda_prev_q;
    logic       scl, sda, scl_rise, scl_fall, start_det, stop_det, addr_hit;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       phase_q, phase_d;
    logic       rw_q, rw_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;

    always_ff @(posedge i2c_clock_in or posedge i2c_reset_in) begin
        if (i2c_reset_in) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], i2c_scl_inout};
            sda_sync_q <= {sda_sync_q[0], i2c_sda_inout};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign scl      = scl_sync_q[1];
    assign sda      = sda_sync_q[1];
    assign scl_rise = scl & ~scl_prev_q;
    assign scl_fall = ~scl & scl_prev_q;
    // SCL must be high in both samples, so an SDA edge coinciding with an SCL edge is never START/STOP.
    assign start_det = ~sda & sda_prev_q & scl & scl_prev_q;
    assign stop_det  = sda & ~sda_prev_q & scl & scl_prev_q;

`ifdef I2C_SLAVE_GEN_CALL_EN
    assign addr_hit = (shift_q == SLAVE_ADDR) || ((shift_q == 7'd0) && !sda);
`else
    assign addr_hit = (shift_q == SLAVE_ADDR);
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_sr_d    = tx_sr_q;
        rx_data_d  = rx_data_q;
        sda_oe_d   = sda_oe_q;
        phase_d    = phase_q;
        rw_d       = rw_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;

        if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = 3'd0;
            shift_d   = 7'd0;
            tx_sr_d   = 8'd0;
            sda_oe_d  = 1'b0;
            phase_d   = 1'b0;
        end else if (stop_det) begin
            state_d   = S_IDLE;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            phase_d   = 1'b0;
        end else begin
            if (tx_req_q) tx_sr_d = slave_data_tx;
            case (state_q)
                S_IDLE: ;
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (addr_hit) begin
                                state_d  = S_ADDR_ACK;
                                rw_d     = sda;
                                tx_req_d = sda;
                                phase_d  = 1'b0;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                end
                // phase_q: 0 = waiting for the fall that starts the ACK clock, 1 = ACK being driven.
                S_ADDR_ACK, S_WR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                state_d  = S_RD_DATA;
                                sda_oe_d = ~tx_sr_q[7];
                            end else begin
                                state_d  = S_WR_DATA;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = {shift_q, sda};
                            rx_valid_d = 1'b1;
                            state_d    = S_WR_ACK;
                            phase_d    = 1'b0;
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            state_d  = S_RD_ACK;
                            phase_d  = 1'b0;
                        end else begin
                            tx_sr_d  = {tx_sr_q[6:0], 1'b0};
                            sda_oe_d = ~tx_sr_q[6];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda) begin
                            state_d = S_IDLE;
                        end else begin
                            tx_req_d = 1'b1;
                            phase_d  = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        phase_d  = 1'b0;
                        state_d  = S_RD_DATA;
                        sda_oe_d = ~tx_sr_q[7];
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i2c_clock_in or posedge i2c_reset_in) begin
        if (i2c_reset_in) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            tx_sr_q    <= 8'd0;
            rx_data_q  <= 8'd0;
            sda_oe_q   <= 1'b0;
            phase_q    <= 1'b0;
            rw_q       <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_sr_q    <= tx_sr_d;
            rx_data_q  <= rx_data_d;
            sda_oe_q   <= sda_oe_d;
            phase_q    <= phase_d;
            rw_q       <= rw_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
        end
    end

    assign i2c_sda_inout = sda_oe_q ? 1'b0 : 1'bz;
    assign i2c_scl_inout = 1'bz;

    assign slave_data_rx = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign tx_req        = tx_req_q;
    assign rw_out        = rw_q;
    assign busy          = (state_q != S_IDLE) && (state_q != S_ADDR);

endmodule

// File: tb/tb_i2c_slave_controller.sv
// Bus-level bench for i2c_slave_controller: open-drain master model, transaction-level expectations, scoreboard monitor.
`timescale 1ns/1ps
module tb_i2c_slave_controller;

    localparam logic [6:0] SADDR = 7'b1010101;
    localparam int Q = 6;
`ifdef I2C_SLAVE_GEN_CALL_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl_low = 1'b0;
    logic       m_sda_low = 1'b0;
    logic [7:0] tx_dat = 8'h00;
    wire        scl_bus, sda_bus;
    logic       tx_req, rx_valid, busy, rw_out;
    logic [7:0] slave_data_rx;

    assign scl_bus = m_scl_low ? 1'b0 : 1'bz;
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (scl_bus);
    pullup (sda_bus);

    i2c_slave_controller dut (
        .i2c_clock_in  (clk),
        .i2c_reset_in  (rst),
        .i2c_scl_inout (scl_bus),
        .i2c_sda_inout (sda_bus),
        .slave_data_tx (tx_dat),
        .tx_req        (tx_req),
        .slave_data_rx (slave_data_rx),
        .rx_valid      (rx_valid),
        .busy          (busy),
        .rw_out        (rw_out)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         dut_low_cnt = 0;
    logic [7:0] exp_rx[$];
    int         exp_tx[$];
    logic [7:0] xdat[4];
    logic [7:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every DUT output pulse must match a queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                check("rx_valid_expected", 32'(exp_rx.size() != 0), 32'd1);
                if (exp_rx.size() != 0) begin
                    mon_e = exp_rx.pop_front();
                    check("rx_data", 32'(slave_data_rx), 32'(mon_e));
                end
            end
            if (tx_req) begin
                check("tx_req_expected", 32'(exp_tx.size() != 0), 32'd1);
                if (exp_tx.size() != 0) begin
                    void'(exp_tx.pop_front());
                    check("tx_req_rw_out", 32'(rw_out), 32'd1);
                end
            end
            if (sda_bus === 1'b0 && !m_sda_low) dut_low_cnt++;
        end
    end

    task automatic wq(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_bit(input bit b, output bit s);
        m_sda_low = !b;
        wq(Q);
        m_scl_low = 1'b0;
        wq(Q);
        s = sda_bus;
        wq(Q);
        m_scl_low = 1'b1;
        wq(Q);
    endtask

    task automatic do_start();
        m_sda_low = 1'b0;
        wq(Q);
        m_scl_low = 1'b0;
        wq(Q);
        m_sda_low = 1'b1;
        wq(Q);
        m_scl_low = 1'b1;
        wq(Q);
    endtask

    task automatic do_stop();
        m_sda_low = 1'b1;
        wq(Q);
        m_scl_low = 1'b0;
        wq(Q);
        m_sda_low = 1'b0;
        wq(2 * Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output bit ack);
        bit s;
        for (int b = 7; b >= 0; b--) bus_bit(d[b], s);
        bus_bit(1'b1, s);
        ack = !s;
    endtask

    // Reference model: a target answers its own address, and general-call writes when enabled.
    task automatic xfer(input logic [6:0] addr, input bit rw, input int n, input bit stop_at_end);
        bit         hit, ack, s;
        int         base;
        logic [7:0] rd;
        hit  = (addr == SADDR) || (GC_EN && addr == 7'd0 && !rw);
        base = dut_low_cnt;
        if (hit) begin
            for (int i = 0; i < n; i++) begin
                if (rw) exp_tx.push_back(i);
                else    exp_rx.push_back(xdat[i]);
            end
        end
        if (rw) tx_dat = xdat[0];
        do_start();
        send_byte({addr, rw}, ack);
        check("addr_ack", 32'(ack), 32'(hit));
        check("busy_after_addr", 32'(busy), 32'(hit));
        if (hit) check("rw_out", 32'(rw_out), 32'(rw));
        for (int i = 0; i < n; i++) begin
            if (!rw) begin
                send_byte(xdat[i], ack);
                check("wr_ack", 32'(ack), 32'(hit));
            end else begin
                rd = 8'h00;
                for (int b = 7; b >= 0; b--) begin
                    bus_bit(1'b1, s);
                    rd[b] = s;
                end
                if (i + 1 < n) tx_dat = xdat[i + 1];
                bus_bit(i + 1 >= n, s);
                check("rd_data", 32'(rd), 32'(hit ? xdat[i] : 8'hFF));
            end
        end
        if (!hit) check("no_dut_drive", 32'(dut_low_cnt - base), 32'd0);
        if (stop_at_end) begin
            do_stop();
            check("busy_after_stop", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [6:0] a;
        bit         rw, s, ack;
        int         n;

        wq(5);
        check("rst_sda", 32'(sda_bus), 32'd1);
        check("rst_tx_req", 32'(tx_req), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rw_out", 32'(rw_out), 32'd0);
        check("rst_rx_data", 32'(slave_data_rx), 32'd0);
        rst = 1'b0;
        wq(10);

        xdat[0] = 8'hD3;
        xfer(SADDR, 1'b0, 1, 1'b1);
        check("rx_hold_d3", 32'(slave_data_rx), 32'hD3);

        xdat[0] = 8'h99;
        xfer(SADDR, 1'b1, 1, 1'b1);
        check("idle_sda_released", 32'(sda_bus), 32'd1);

        xdat[0] = 8'h5A;
        xfer(7'b1011001, 1'b0, 1, 1'b1);

        xdat[0] = 8'h6E;
        xdat[1] = 8'hB1;
        xfer(SADDR, 1'b1, 2, 1'b0);
        xdat[0] = 8'h3C;
        xfer(SADDR, 1'b0, 1, 1'b1);
        check("rep_start_rw_out", 32'(rw_out), 32'd0);
        check("rx_hold_3c", 32'(slave_data_rx), 32'h3C);

        // Reset while the target drives a zero bit of a read byte.
        tx_dat = 8'h00;
        exp_tx.push_back(0);
        do_start();
        send_byte({SADDR, 1'b1}, ack);
        check("rst_case_addr_ack", 32'(ack), 32'd1);
        bus_bit(1'b1, s);
        check("rst_case_bit7", 32'(s), 32'd0);
        check("rst_case_driving", 32'(sda_bus), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_sda", 32'(sda_bus), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_tx_req", 32'(tx_req), 32'd0);
        check("rst_mid_rw_out", 32'(rw_out), 32'd0);
        check("rst_mid_rx_data", 32'(slave_data_rx), 32'd0);
        m_scl_low = 1'b0;
        m_sda_low = 1'b0;
        wq(5);
        rst = 1'b0;
        wq(10);
        xdat[0] = 8'h81;
        xfer(SADDR, 1'b0, 1, 1'b1);

        xdat[0] = 8'hA5;
        xfer(7'd0, 1'b0, 1, 1'b1);
        xfer(7'd0, 1'b1, 1, 1'b1);

        for (int t = 0; t < 12; t++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = SADDR;
                2:       a = 7'd0;
                default: a = 7'($urandom_range(0, 127));
            endcase
            rw = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) xdat[k] = 8'($urandom);
            xfer(a, rw, n, 1'b1);
        end

        wq(10);
        check("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
        check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
